// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a one-entry skid buffer and flush-to-bubble
module pipe_stage_skid #(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic              main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q, in_ready_d;
  logic              accept, pop;
  assign accept    = in_valid && in_ready_q;
  assign pop       = main_v_q && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = main_v_q;
  assign out_data  = main_q;
  assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
  // next state: move payloads between input, main and skid; flush empties everything to the bubble
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        main_d  = accept ? in_data : main_q;
        state_d = accept ? ONE : EMPTY;
      end
      ONE: begin
        main_d  = accept && pop ? in_data : pop ? BUBBLE_VAL : main_q;
        skid_d  = accept && !pop ? in_data : skid_q;
        state_d = accept && !pop ? FULL : pop && !accept ? EMPTY : ONE;
      end
      FULL: begin
        main_d  = pop ? skid_q : main_q;
        skid_d  = pop ? BUBBLE_VAL : skid_q;
        state_d = pop ? ONE : FULL;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end
    main_v_d   = state_d != EMPTY;
    skid_v_d   = state_d == FULL;
    in_ready_d = state_d != FULL;
  end
  // state and payload registers; in_ready and valid bits come straight from flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= BUBBLE_VAL;
      skid_q     <= BUBBLE_VAL;
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= in_ready_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scoreboard bench for pipe_stage_skid with directed and random traffic
module tb_pipe_stage_skid;
  localparam logic [63:0] BUBBLE = 64'd0;
  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [1:0]  occupancy;
  logic        mon_en = 1'b0;
  logic        stall_q = 1'b0;
  logic [63:0] stall_data = 64'd0;
  logic [63:0] sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  pipe_stage_skid #(.DATA_W(64), .BUBBLE_VAL(BUBBLE)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input logic v, input logic [63:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask
  // model of stage contents: outputs checked against it, then updated with this cycle's handshake
  always @(negedge clk) if (mon_en) begin
    int n;
    logic acc, pp;
    n = sb.size();
    check("occ", 64'(occupancy), 64'(n));
    check("in_ready", 64'(in_ready), 64'(n < 2));
    check("out_valid", 64'(out_valid), 64'(n != 0));
    if (n == 0) check("bubble", out_data, BUBBLE);
    else check("head", out_data, sb[0]);
    if (stall_q) check("stable", out_data, stall_data);
    acc = in_valid && n < 2;
    pp  = out_ready && n != 0;
    stall_q <= !rst && !flush && n != 0 && !out_ready;
    stall_data <= n != 0 ? sb[0] : BUBBLE;
    if (pp) check("data", out_data, sb.pop_front());
    if (rst || flush) sb.delete();
    else if (acc) sb.push_back(in_data);
  end
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 64'hAAAA; out_ready = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("rst_vld", 64'(out_valid), 64'd0);
    check("rst_data", out_data, BUBBLE);
    rst = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    check("rel_vld", 64'(out_valid), 64'd0);
    check("rel_occ", 64'(occupancy), 64'd0);
    check("rel_rdy", 64'(in_ready), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 64'(i), 1'b1, 1'b0);
      check("str_data", out_data, 64'(i));
      check("str_occ", 64'(occupancy), 64'd1);
      check("str_rdy", 64'(in_ready), 64'd1);
    end
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    check("str_empty", out_data, BUBBLE);
    drive(1'b1, 64'h10, 1'b0, 1'b0);
    check("skid_one", out_data, 64'h10);
    drive(1'b1, 64'h11, 1'b0, 1'b0);
    check("skid_occ", 64'(occupancy), 64'd2);
    check("skid_rdy", 64'(in_ready), 64'd0);
    check("skid_hold", out_data, 64'h10);
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    check("skid_hold2", out_data, 64'h10);
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    check("skid_second", out_data, 64'h11);
    check("skid_rdy_up", 64'(in_ready), 64'd1);
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    check("skid_drained", 64'(occupancy), 64'd0);
    drive(1'b1, 64'h20, 1'b0, 1'b0);
    drive(1'b1, 64'h21, 1'b0, 1'b0);
    check("fl_full", 64'(occupancy), 64'd2);
    drive(1'b1, 64'h22, 1'b0, 1'b1);
    check("fl_occ", 64'(occupancy), 64'd0);
    check("fl_vld", 64'(out_valid), 64'd0);
    check("fl_data", out_data, BUBBLE);
    check("fl_rdy", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 64'd0, 1'b1, 1'b0);
      check("fl_gone", 64'(out_valid), 64'd0);
    end
    drive(1'b1, 64'h30, 1'b0, 1'b0);
    check("dr_one", out_data, 64'h30);
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    check("dr_empty", out_data, BUBBLE);
    check("dr_occ", 64'(occupancy), 64'd0);
    drive(1'b1, 64'h31, 1'b1, 1'b0);
    check("dr_next", out_data, 64'h31);
    check("dr_vld", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10000; i++)
      drive(1'($urandom_range(0, 1)), {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 64'd0, 1'b1, 1'b0);
    check("final_empty", 64'(sb.size()), 64'd0);
    check("final_occ", 64'(occupancy), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
